// File: rtl/lpc_cycle_stream_pkg.sv
`default_nettype none
// ============================================================================
// lpc_cycle_stream_pkg : record layout, serializer states, byte-select helper
// Revision: 1.0
// ============================================================================
package lpc_cycle_stream_pkg;

  localparam int REC_BYTES = 4;
  localparam logic [1:0] REC_LAST_IDX = 2'(REC_BYTES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  typ;
  } lpc_rec_t;

  // Records are emitted big-endian: index 0 is bits [31:24].
  function automatic logic [7:0] rec_byte(input lpc_rec_t rec, input logic [1:0] idx);
    logic [31:0] w;
    w = rec;
    case (idx)
      2'd0:    rec_byte = w[31:24];
      2'd1:    rec_byte = w[23:16];
      2'd2:    rec_byte = w[15:8];
      default: rec_byte = w[7:0];
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lpc_cycle_stream_if.sv
`default_nettype none
// ============================================================================
// lpc_cycle_stream_if : byte stream valid/ready handshake toward the host bridge
// Revision: 1.0
// ============================================================================
interface lpc_cycle_stream_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/lpc_cycle_stream_sync_fifo.sv
`default_nettype none
// ============================================================================
// lpc_sync_fifo : single-clock FIFO, extra pointer MSB distinguishes full/empty
// Revision: 1.0
// ============================================================================
module lpc_sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  wire logic                  clk_i,
  input  wire logic                  nrst_i,
  input  wire logic                  push_i,
  input  wire logic                  pop_i,
  input  wire logic [WIDTH-1:0]      wdata_i,
  output logic      [WIDTH-1:0]      rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic      [DEPTH_LOG2:0]   level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                do_push, do_pop;

  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
              (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    level_o = wr_ptr_q - rd_ptr_q;
    do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot being written, so full does not block.
    do_push = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, do_pop};
    rdata_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/lpc_cycle_stream.sv
`default_nettype none
// ============================================================================
// lpc_cycle_stream : buffers LPC cycle records and drains them as a byte stream
// Revision: 1.0
// ============================================================================
module lpc_cycle_stream
  import lpc_cycle_stream_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_W      = 16
) (
  input  wire logic                clk_i,
  input  wire logic                nrst_i,
  input  wire logic [31:0]         tdata_i,
  input  wire logic                ready_i,
  lpc_cycle_stream_if.master       m_axis,
  output logic      [DEPTH_LOG2:0] fifo_level_o,
  output logic                     overflow_o,
  output logic      [CNT_W-1:0]    ovf_cnt_o,
  input  wire logic                clr_ovf_i
);

  logic             ready_q;
  logic             push, pop, full, empty, accept, load, drop;
  logic [31:0]      rdata;
  logic [0:0]       state_q, state_d;
  lpc_rec_t         word_q, word_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  lpc_sync_fifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (tdata_i),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level_o)
  );

  always_comb begin
    push     = ready_i & ~ready_q;
    accept   = tvalid_q & m_axis.tready;
    load     = 1'b0;
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    if (state_q == ST_IDLE) begin
      load = ~empty;
    end else if (accept) begin
      if (idx_q == REC_LAST_IDX) begin
        // Reload straight from the FIFO so consecutive records leave no gap.
        if (!empty) begin
          load = 1'b1;
        end else begin
          state_d  = ST_IDLE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
      end else begin
        idx_d   = idx_q + 2'd1;
        tdata_d = rec_byte(word_q, idx_q + 2'd1);
        tlast_d = (idx_q + 2'd1 == REC_LAST_IDX);
      end
    end
    if (load) begin
      state_d  = ST_SEND;
      word_d   = rdata;
      idx_d    = 2'd0;
      tdata_d  = rdata[31:24];
      tvalid_d = 1'b1;
      tlast_d  = 1'b0;
    end
    pop = load;
  end

  always_comb begin
    drop  = push & full & ~pop;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (clr_ovf_i) begin
      ovf_d = drop;
      cnt_d = {{(CNT_W-1){1'b0}}, drop};
    end else if (drop) begin
      ovf_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ready_q  <= 1'b0;
      state_q  <= ST_IDLE;
      word_q   <= '0;
      idx_q    <= 2'd0;
      tdata_q  <= 8'd0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ready_q  <= ready_i;
      state_q  <= state_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign overflow_o    = ovf_q;
  assign ovf_cnt_o     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lpc_cycle_stream.sv
`default_nettype none
// ============================================================================
// tb_lpc_cycle_stream : directed stimulus with a record-level reference model
// Revision: 1.0
// ============================================================================
module tb_lpc_cycle_stream;

  localparam int DL    = 4;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [31:0]   tdata = '0;
  logic          ready = 1'b0;
  logic          clr = 1'b0;
  logic [DL:0]   level;
  logic          ovf;
  logic [CW-1:0] ovf_cnt;

  lpc_cycle_stream_if sif();

  lpc_cycle_stream #(.DEPTH_LOG2(DL), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .nrst_i       (nrst),
    .tdata_i      (tdata),
    .ready_i      (ready),
    .m_axis       (sif),
    .fifo_level_o (level),
    .overflow_o   (ovf),
    .ovf_cnt_o    (ovf_cnt),
    .clr_ovf_i    (clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_acc  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: records waiting, whether a record is on the wire, and how
  // many of its bytes have gone; expected bytes queued in arrival order.
  int         m_waiting;
  bit         m_busy;
  int         m_sent;
  bit         m_ready_q;
  bit         m_ovf;
  int         m_cnt;
  logic [7:0] exp_q[$];
  bit         prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clk) begin
    bit macc, last, edge_seen, pop, push_ok, drop;
    logic [7:0] e;
    if (!nrst) begin
      m_waiting = 0; m_busy = 0; m_sent = 0; m_ready_q = 0;
      m_ovf = 0; m_cnt = 0; exp_q.delete(); prev_stall = 0;
      chk("rst_tvalid", {31'd0, sif.tvalid}, 32'd0);
      chk("rst_tlast",  {31'd0, sif.tlast},  32'd0);
      chk("rst_tdata",  {24'd0, sif.tdata},  32'd0);
      chk("rst_level",  32'(level), 32'd0);
      chk("rst_ovf",    {31'd0, ovf}, 32'd0);
      chk("rst_cnt",    32'(ovf_cnt), 32'd0);
    end else begin
      chk("level",  32'(level), 32'(m_waiting));
      chk("ovf",    {31'd0, ovf}, {31'd0, m_ovf});
      chk("cnt",    32'(ovf_cnt), 32'(m_cnt));
      chk("tvalid", {31'd0, sif.tvalid}, {31'd0, m_busy});
      if (prev_stall) begin
        chk("stall_data", {24'd0, sif.tdata}, {24'd0, prev_data});
        chk("stall_last", {31'd0, sif.tlast}, {31'd0, prev_last});
      end
      if (sif.tvalid && sif.tready) begin
        n_acc++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", sif.tdata);
        end else begin
          e = exp_q.pop_front();
          chk("byte", {24'd0, sif.tdata}, {24'd0, e});
          chk("tlast", {31'd0, sif.tlast}, {31'd0, m_sent == 3});
        end
      end
      prev_stall = sif.tvalid && !sif.tready;
      prev_data  = sif.tdata;
      prev_last  = sif.tlast;

      macc      = m_busy && sif.tready;
      last      = macc && (m_sent == 3);
      edge_seen = ready && !m_ready_q;
      pop       = (m_waiting > 0) && (!m_busy || last);
      push_ok   = edge_seen && ((m_waiting < DEPTH) || pop);
      drop      = edge_seen && !push_ok;
      if (macc) m_sent++;
      if (last) begin m_busy = 0; m_sent = 0; end
      if (pop)  begin m_busy = 1; m_sent = 0; m_waiting--; end
      if (push_ok) begin
        m_waiting++;
        for (int i = 0; i < 4; i++) exp_q.push_back(tdata[31-8*i -: 8]);
      end
      if (clr) begin
        m_ovf = drop; m_cnt = drop ? 1 : 0;
      end else if (drop) begin
        m_ovf = 1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      m_ready_q = ready;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [31:0] w);
    tick; tdata = w; ready = 1'b1;
    tick; ready = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int k = 0;
    do begin tick; k++; end while ((sif.tvalid || level != 0) && k < maxc);
    checks++;
    if (k >= maxc) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cycles expected below %0d", k, maxc);
    end
  endtask

  // Literal latency/byte-order check: bytes on cycles N+2..N+5 after a rising edge at N.
  task automatic send_rec_check(input logic [31:0] w);
    logic [7:0] b;
    pulse(w);
    for (int i = 0; i < 4; i++) begin
      tick; @(negedge clk);
      b = w[31-8*i -: 8];
      chk("lit_valid", {31'd0, sif.tvalid}, 32'd1);
      chk("lit_byte",  {24'd0, sif.tdata}, {24'd0, b});
      chk("lit_last",  {31'd0, sif.tlast}, {31'd0, i == 3});
    end
    tick; @(negedge clk);
    chk("lit_idle",  {31'd0, sif.tvalid}, 32'd0);
    chk("lit_level", 32'(level), 32'd0);
  endtask

  initial begin
    int snap;
    sif.tready = 1'b1;
    repeat (3) tick;
    nrst = 1'b1;
    tick;

    // 1: single record, fixed latency
    send_rec_check(32'h0080_A502);

    // 2: READY held high for several cycles yields one record
    snap = n_acc;
    tick; tdata = 32'h1111_2222; ready = 1'b1;
    repeat (5) tick;
    ready = 1'b0;
    repeat (10) tick;
    chk("held_bytes", 32'(n_acc - snap), 32'd4);
    chk("held_cnt", 32'(ovf_cnt), 32'd0);

    // 3: stalled sink; one record on the wire, 16 buffered, two dropped
    sif.tready = 1'b0;
    for (int i = 0; i < 19; i++) pulse(32'hA000_0000 + i);
    tick; @(negedge clk);
    chk("full_level", 32'(level), 32'd16);
    chk("full_ovf",   {31'd0, ovf}, 32'd1);
    chk("full_cnt",   32'(ovf_cnt), 32'd2);
    tick; tdata = 32'hDEAD_0001; ready = 1'b1; clr = 1'b1;
    tick; ready = 1'b0; clr = 1'b0;
    @(negedge clk);
    chk("clr_drop_ovf", {31'd0, ovf}, 32'd1);
    chk("clr_drop_cnt", 32'(ovf_cnt), 32'd1);

    // 4: push lands on the byte-3 pop while full
    snap = n_acc;
    tick; sif.tready = 1'b1;
    tick;
    tick;
    tick; tdata = 32'hBEEF_0004; ready = 1'b1;
    tick; ready = 1'b0;
    @(negedge clk);
    chk("swap_level", 32'(level), 32'd16);
    chk("swap_cnt",   32'(ovf_cnt), 32'd1);
    wait_drain(200);
    chk("drain_bytes", 32'(n_acc - snap), 32'd72);

    // 5: random sink stalls mid-record, then clear the overflow state
    for (int r = 0; r < 3; r++) pulse(32'h5A00_0000 + 32'(r * 32'h0101_0101));
    for (int i = 0; i < 40; i++) begin
      tick; sif.tready = 1'($urandom_range(0, 1));
    end
    tick; sif.tready = 1'b1;
    wait_drain(100);
    tick; clr = 1'b1;
    tick; clr = 1'b0;
    @(negedge clk);
    chk("clr_ovf", {31'd0, ovf}, 32'd0);
    chk("clr_cnt", 32'(ovf_cnt), 32'd0);

    // 6: reset after byte 1, then a fresh record starts at byte 0
    pulse(32'hCAFE_F00D);
    tick;
    tick;
    tick; nrst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, sif.tvalid}, 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    tick;
    tick; nrst = 1'b1;
    tick;
    send_rec_check(32'h1234_5601);

    repeat (3) tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
